// File: rtl/sequence_generator.sv
// Serial bit-pattern source: emits a captured pattern MSB-first, one bit per advance,
// with optional repeats separated by a fixed run of zero bits.
module sequence_generator #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int REP_W   = 4,
   parameter int GAP_LEN = 2
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic               abort,
   input  logic               advance,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   length,
   input  logic [REP_W-1:0]   repeat_count,
   output logic               w_out,
   output logic               w_valid,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         state,
   output logic [LEN_W-1:0]   bit_index
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_t             r_state,     w_state_nxt;
   logic [MAX_LEN-1:0] r_pat,       w_pat_nxt;
   logic [LEN_W-1:0]   r_len,       w_len_nxt;
   logic [REP_W-1:0]   r_reps,      w_reps_nxt;
   logic [LEN_W-1:0]   r_bit_index, w_bit_index_nxt;
   logic [GAP_W-1:0]   r_gap_cnt,   w_gap_cnt_nxt;
   logic               r_err,       w_err_nxt;

   logic               w_start_ok;
   logic               w_last_bit;
   logic               w_gap_last;
   logic [LEN_W-1:0]   w_sel;
   logic [MAX_LEN-1:0] w_mask;

   assign w_start_ok = (length != '0) && (length <= MAX_LEN_L);
   assign w_last_bit = (r_bit_index == (r_len - LEN_W'(1)));
   assign w_gap_last = (int'(r_gap_cnt) == (GAP_LEN - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_pat       <= '0;
         r_len       <= '0;
         r_reps      <= '0;
         r_bit_index <= '0;
         r_gap_cnt   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pat       <= w_pat_nxt;
         r_len       <= w_len_nxt;
         r_reps      <= w_reps_nxt;
         r_bit_index <= w_bit_index_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
         r_err       <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pat_nxt       = r_pat;
      w_len_nxt       = r_len;
      w_reps_nxt      = r_reps;
      w_bit_index_nxt = r_bit_index;
      w_gap_cnt_nxt   = r_gap_cnt;
      w_err_nxt       = 1'b0;
      case (r_state)
         S_IDLE: begin
            // start outranks abort here; abort has nothing to cancel in IDLE
            if (start) begin
               if (w_start_ok) begin
                  w_pat_nxt       = pattern;
                  w_len_nxt       = length;
                  w_reps_nxt      = repeat_count;
                  w_bit_index_nxt = '0;
                  w_gap_cnt_nxt   = '0;
                  w_state_nxt     = S_SHIFT;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            if (abort) begin
               w_bit_index_nxt = '0;
               w_state_nxt     = S_IDLE;
            end else if (advance) begin
               if (!w_last_bit) begin
                  w_bit_index_nxt = r_bit_index + LEN_W'(1);
               end else if (r_reps != '0) begin
                  w_reps_nxt      = r_reps - REP_W'(1);
                  w_bit_index_nxt = '0;
                  w_state_nxt     = (GAP_LEN > 0) ? S_GAP : S_SHIFT;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               w_bit_index_nxt = '0;
               w_gap_cnt_nxt   = '0;
               w_state_nxt     = S_IDLE;
            end else if (advance) begin
               if (w_gap_last) begin
                  w_gap_cnt_nxt   = '0;
                  w_bit_index_nxt = '0;
                  w_state_nxt     = S_SHIFT;
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
               end
            end
         end
         S_DONE: begin
            w_bit_index_nxt = '0;
            w_state_nxt     = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Bit [len-1] goes out first, so the selected position counts down from the top.
   assign w_sel     = r_len - LEN_W'(1) - r_bit_index;
   assign w_mask    = MAX_LEN'(1) << w_sel;
   assign w_out     = (r_state == S_SHIFT) && ((r_pat & w_mask) != '0);
   assign w_valid   = (r_state == S_SHIFT) || (r_state == S_GAP);
   assign busy      = (r_state == S_SHIFT) || (r_state == S_GAP);
   assign done      = (r_state == S_DONE);
   assign err       = r_err;
   assign state     = r_state;
   assign bit_index = r_bit_index;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: fixed vector table, hand-written corner sequences,
// and randomized runs checked against a stream-level reference model.
module tb_sequence_generator;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int REP_W   = 4;
   localparam int GAP_LEN = 2;

   logic               clock;
   logic               resetn;
   logic               start;
   logic               abort;
   logic               advance;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   length;
   logic [REP_W-1:0]   repeat_count;
   logic               w_out;
   logic               w_valid;
   logic               busy;
   logic               done;
   logic               err;
   logic [1:0]         state;
   logic [LEN_W-1:0]   bit_index;

   int n_cmp;
   int n_fail;

   sequence_generator #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .REP_W   (REP_W),
      .GAP_LEN (GAP_LEN)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .start        (start),
      .abort        (abort),
      .advance      (advance),
      .pattern      (pattern),
      .length       (length),
      .repeat_count (repeat_count),
      .w_out        (w_out),
      .w_valid      (w_valid),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .state        (state),
      .bit_index    (bit_index)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       start;
      logic       abort;
      logic       adv;
      logic [3:0] len;
      logic [7:0] pat;
      logic [3:0] rep;
      logic [1:0] st;
      logic       w;
      logic       v;
      logic       bsy;
      logic       dn;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; abort = 1'b0; advance = 1'b0;
   endtask

   task automatic add(input logic s, input logic a, input logic adv, input logic [3:0] len,
                      input logic [7:0] pat, input logic [3:0] rep, input logic [1:0] st,
                      input logic w, input logic v, input logic bsy, input logic dn, input logic er);
      vec_t t;
      t.start = s; t.abort = a; t.adv = adv; t.len = len; t.pat = pat; t.rep = rep;
      t.st = st; t.w = w; t.v = v; t.bsy = bsy; t.dn = dn; t.er = er;
      vecs.push_back(t);
   endtask

   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) begin
         start = vecs[i].start; abort = vecs[i].abort; advance = vecs[i].adv;
         length = vecs[i].len; pattern = vecs[i].pat; repeat_count = vecs[i].rep;
         tick();
         check($sformatf("tbl%0d_state", i), state, vecs[i].st);
         check($sformatf("tbl%0d_w_out", i), w_out, vecs[i].w);
         check($sformatf("tbl%0d_w_valid", i), w_valid, vecs[i].v);
         check($sformatf("tbl%0d_busy", i), busy, vecs[i].bsy);
         check($sformatf("tbl%0d_done", i), done, vecs[i].dn);
         check($sformatf("tbl%0d_err", i), err, vecs[i].er);
      end
      idle_inputs();
   endtask

   // Reference model: the whole run is flattened into the list of presented symbols.
   task automatic run_random(input int runs);
      logic [LEN_W-1:0] exp_q[$];
      logic [LEN_W-1:0] idx_q[$];
      logic [LEN_W-1:0] gap_q[$];
      logic [7:0] pat_v;
      int len_v, rep_v, pos, cycles;
      bit aborted, adv_v, ab_v;
      for (int r = 0; r < runs; r++) begin
         exp_q.delete(); idx_q.delete(); gap_q.delete();
         pat_v = 8'($urandom);
         len_v = $urandom_range(1, MAX_LEN);
         rep_v = $urandom_range(0, 3);
         for (int p = 0; p <= rep_v; p++) begin
            if (p > 0)
               for (int g = 0; g < GAP_LEN; g++) begin
                  exp_q.push_back(0); idx_q.push_back(0); gap_q.push_back(1);
               end
            for (int i = 0; i < len_v; i++) begin
               exp_q.push_back(LEN_W'(pat_v[len_v-1-i]));
               idx_q.push_back(LEN_W'(i));
               gap_q.push_back(0);
            end
         end
         start = 1'b1; abort = 1'b0; advance = 1'($urandom);
         pattern = pat_v; length = LEN_W'(len_v); repeat_count = REP_W'(rep_v);
         tick();
         pos = 0; cycles = 0; aborted = 0;
         while (pos < exp_q.size() && !aborted && cycles < 1000) begin
            check("rnd_state", state, (gap_q[pos] != 0) ? 2 : 1);
            check("rnd_w_out", w_out, exp_q[pos]);
            check("rnd_w_valid", w_valid, 1);
            check("rnd_busy", busy, 1);
            check("rnd_bit_index", bit_index, idx_q[pos]);
            check("rnd_done", done, 0);
            check("rnd_err", err, 0);
            adv_v = 1'($urandom_range(0, 1));
            ab_v  = ($urandom_range(0, 49) == 0);
            advance = adv_v; abort = ab_v;
            start = 1'($urandom_range(0, 1));
            pattern = 8'($urandom); length = LEN_W'($urandom_range(0, 15));
            repeat_count = REP_W'($urandom);
            tick();
            cycles++;
            if (ab_v) aborted = 1;
            else if (adv_v) pos++;
         end
         check("rnd_cycle_budget", (cycles < 1000) ? 1 : 0, 1);
         idle_inputs();
         if (aborted) begin
            check("rnd_abort_state", state, 0);
            check("rnd_abort_valid", w_valid, 0);
            check("rnd_abort_done", done, 0);
            check("rnd_abort_idx", bit_index, 0);
         end else begin
            check("rnd_end_state", state, 3);
            check("rnd_end_done", done, 1);
            check("rnd_end_busy", busy, 0);
            check("rnd_end_valid", w_valid, 0);
            tick();
            check("rnd_idle_state", state, 0);
            check("rnd_idle_done", done, 0);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      resetn = 1'b0;
      idle_inputs();
      pattern = '0; length = '0; repeat_count = '0;
      #12;
      check("rst_state", state, 0);
      check("rst_w_out", w_out, 0);
      check("rst_w_valid", w_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_idx", bit_index, 0);
      resetn = 1'b1;
      tick();

      // start  abort adv len pat    rep  | state w v busy done err
      add(1, 0, 1, 4, 8'h0F, 0,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0F, 0,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0F, 0,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0F, 0,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0F, 0,  3, 0, 0, 0, 1, 0);
      add(0, 0, 1, 4, 8'h0F, 0,  0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 8'hFF, 0,  0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 8'hFF, 0,  0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 9, 8'hFF, 0,  0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 9, 8'hFF, 0,  0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 8'h01, 0,  1, 1, 1, 1, 0, 0);
      add(0, 0, 0, 1, 8'h00, 0,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 1, 8'h00, 0,  3, 0, 0, 0, 1, 0);
      add(1, 0, 0, 4, 8'h0F, 0,  0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 4, 8'h0F, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 1, 8'h00, 0,  1, 0, 1, 1, 0, 0);
      add(0, 0, 1, 1, 8'h00, 0,  3, 0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 8'h00, 0,  0, 0, 0, 0, 0, 0);
      // 1101 twice with a two-zero gap
      add(1, 0, 1, 4, 8'h0D, 1,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  1, 0, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  2, 0, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  2, 0, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  1, 0, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 4, 8'h0D, 1,  3, 0, 0, 0, 1, 0);
      add(0, 0, 0, 4, 8'h0D, 1,  0, 0, 0, 0, 0, 0);
      run_table();

      // abort at bit_index 2 of an 8-bit run
      start = 1'b1; advance = 1'b1; length = 4'd8; pattern = 8'hA5; repeat_count = 4'd0;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("abort_pre_idx", bit_index, 2);
      check("abort_pre_w_out", w_out, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0; advance = 1'b0;
      check("abort_state", state, 0);
      check("abort_valid", w_valid, 0);
      check("abort_done", done, 0);
      check("abort_idx", bit_index, 0);
      tick();
      check("abort_no_done", done, 0);
      run_random(1);

      // asynchronous reset in the middle of a gap
      start = 1'b1; advance = 1'b1; length = 4'd2; pattern = 8'h02; repeat_count = 4'd1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("gap_reached", state, 2);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_valid", w_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_idx", bit_index, 0);
      #1;
      resetn = 1'b1;
      idle_inputs();
      tick();
      check("post_rst_state", state, 0);
      run_random(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
